// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC frame scheduler.
//  - state_e      : scheduler FSM states
//  - STAT_*       : out_status encodings {timeout, converged}
//  - log2()       : ceil(log2(v)), minimum 1, for deriving counter widths
package ldpc_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [1:0] STAT_CONV    = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;

    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/ldpc_llr_pingpong.sv
// Two-slot ping-pong store for channel-LLR frames.
// Ports:
//  clk, rst    clock, synchronous active-low reset
//  wr_en       write request (gated internally by in_ready)
//  wr_data     frame to store in slot wr_ptr
//  rd_free     release slot rd_ptr (result captured)
//  in_ready    slot wr_ptr is empty; depends on registers only
//  rd_full     slot rd_ptr holds a frame
//  rd_data     contents of slot rd_ptr
module ldpc_llr_pingpong #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_free,
    output logic         in_ready,
    output logic         rd_full,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] slot_q [2];
    logic [1:0]   full_q, full_d;
    logic         wr_ptr_q, rd_ptr_q;
    logic         wr_fire;

    assign in_ready = !full_q[wr_ptr_q];
    assign rd_full  = full_q[rd_ptr_q];
    assign rd_data  = slot_q[rd_ptr_q];
    assign wr_fire  = wr_en && in_ready;

    // A freed slot only shows up in in_ready on the following cycle, since
    // in_ready is decoded from full_q rather than full_d.
    always_comb begin
        full_d = full_q;
        if (wr_fire) full_d[wr_ptr_q] = 1'b1;
        if (rd_free) full_d[rd_ptr_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q   <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (wr_fire) wr_ptr_q <= !wr_ptr_q;
            if (rd_free) rd_ptr_q <= !rd_ptr_q;
        end
    end

    // Payload needs no reset; full flags qualify it.
    always_ff @(posedge clk) begin
        if (wr_fire) slot_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ldpc_core_sched.sv
// LDPC frame scheduler: ping-pong buffers channel-LLR frames, sequences the
// external CNU/VNU array per frame (clear, then iterate until syndrome pass or
// iteration limit) and returns hard decisions over a valid/ready port.
// Ports:
//  clk, rst                 clock, synchronous active-low reset
//  in_valid/in_ready/in_llr input frame handshake and channel LLRs
//  max_iter                 per-frame iteration limit, sampled in CLEAR
//  arr_l/arr_clr/arr_en     array drive: active LLRs, message clear, iterate
//  arr_dec/syn_ok           array hard decisions and parity-check pass
//  out_valid/out_ready      result handshake
//  out_bits/out_iters/out_status  decoded bits, iterations, {timeout, conv}
//  cnt_ok/cnt_fail          saturating converged / timeout frame counters
module ldpc_core_sched
    import ldpc_pkg::*;
#(
    parameter int unsigned data_w   = 5,
    parameter int unsigned R        = 24,
    parameter int unsigned D        = 96,
    parameter int unsigned IT_W     = 6,
    parameter int unsigned MIN_PASS = 1,
    parameter int unsigned ST_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [R*D*data_w-1:0] in_llr,
    input  logic [IT_W-1:0]       max_iter,
    output logic [R*D*data_w-1:0] arr_l,
    output logic                  arr_clr,
    output logic                  arr_en,
    input  logic [R*D-1:0]        arr_dec,
    input  logic                  syn_ok,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [R*D-1:0]        out_bits,
    output logic [IT_W-1:0]       out_iters,
    output logic [1:0]            out_status,
    output logic [ST_W-1:0]       cnt_ok,
    output logic [ST_W-1:0]       cnt_fail
);

    localparam int unsigned N      = R * D;
    localparam int unsigned PASS_W = log2(MIN_PASS + 1);

    state_e              state_q, state_d;
    logic [IT_W-1:0]     iter_q, iter_d;
    logic [IT_W-1:0]     lim_q, lim_d;
    logic [PASS_W-1:0]   pass_q, pass_d, pass_inc;
    logic                conv_q, conv_d;
    logic                out_valid_q, out_valid_d;
    logic [N-1:0]        out_bits_q, out_bits_d;
    logic [IT_W-1:0]     out_iters_q, out_iters_d;
    logic [1:0]          out_status_q, out_status_d;
    logic [ST_W-1:0]     cnt_ok_q, cnt_ok_d;
    logic [ST_W-1:0]     cnt_fail_q, cnt_fail_d;
    logic                capture;
    logic                rd_full;

    ldpc_llr_pingpong #(
        .W (N * data_w)
    ) u_pingpong (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (in_valid),
        .wr_data  (in_llr),
        .rd_free  (capture),
        .in_ready (in_ready),
        .rd_full  (rd_full),
        .rd_data  (arr_l)
    );

    // Result register is free when empty or being drained this cycle.
    assign capture  = (state_q == StDone) && (!out_valid_q || out_ready);
    assign pass_inc = pass_q + PASS_W'(1);

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        lim_d   = lim_q;
        pass_d  = pass_q;
        conv_d  = conv_q;
        arr_clr = 1'b0;
        arr_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rd_full) state_d = StClear;
            end
            StClear: begin
                arr_clr = 1'b1;
                iter_d  = '0;
                pass_d  = '0;
                lim_d   = max_iter;
                state_d = StRun;
            end
            StRun: begin
                // Convergence outranks the limit, so max_iter=0 with a
                // passing syndrome still reports converged.
                if (syn_ok && (pass_inc >= PASS_W'(MIN_PASS))) begin
                    conv_d  = 1'b1;
                    state_d = StDone;
                end else if (iter_q == lim_q) begin
                    conv_d  = 1'b0;
                    state_d = StDone;
                end else begin
                    arr_en = 1'b1;
                    iter_d = iter_q + IT_W'(1);
                    pass_d = syn_ok ? pass_inc : '0;
                end
            end
            StDone: begin
                if (capture) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_bits_d   = out_bits_q;
        out_iters_d  = out_iters_q;
        out_status_d = out_status_q;
        cnt_ok_d     = cnt_ok_q;
        cnt_fail_d   = cnt_fail_q;
        if (capture) begin
            out_valid_d  = 1'b1;
            out_bits_d   = arr_dec;
            out_iters_d  = iter_q;
            out_status_d = conv_q ? STAT_CONV : STAT_TIMEOUT;
            if (conv_q) begin
                if (cnt_ok_q != '1) cnt_ok_d = cnt_ok_q + ST_W'(1);
            end else begin
                if (cnt_fail_q != '1) cnt_fail_d = cnt_fail_q + ST_W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            iter_q       <= '0;
            lim_q        <= '0;
            pass_q       <= '0;
            conv_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_bits_q   <= '0;
            out_iters_q  <= '0;
            out_status_q <= '0;
            cnt_ok_q     <= '0;
            cnt_fail_q   <= '0;
        end else begin
            state_q      <= state_d;
            iter_q       <= iter_d;
            lim_q        <= lim_d;
            pass_q       <= pass_d;
            conv_q       <= conv_d;
            out_valid_q  <= out_valid_d;
            out_bits_q   <= out_bits_d;
            out_iters_q  <= out_iters_d;
            out_status_q <= out_status_d;
            cnt_ok_q     <= cnt_ok_d;
            cnt_fail_q   <= cnt_fail_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_bits   = out_bits_q;
    assign out_iters  = out_iters_q;
    assign out_status = out_status_q;
    assign cnt_ok     = cnt_ok_q;
    assign cnt_fail   = cnt_fail_q;

endmodule

// File: tb/tb_ldpc_core_sched.sv
// Scoreboard bench for ldpc_core_sched. Each instance drives a behavioural
// array model: arr_dec = sign bits of arr_l XOR parity of the arr_en count
// since the last arr_clr, so out_bits also proves which slot and which
// iteration were captured. syn_ok is a function of that arr_en count.
module tb_ldpc_core_sched;

    localparam int unsigned R  = 2;
    localparam int unsigned D  = 4;
    localparam int unsigned DW = 5;
    localparam int unsigned N  = R * D;
    localparam int unsigned LW = N * DW;
    localparam int unsigned IW = 6;
    localparam int unsigned SW = 16;

    typedef struct {
        logic [N-1:0]  bits;
        logic [IW-1:0] iters;
        logic [1:0]    st;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic logic [N-1:0] signs(input logic [LW-1:0] v);
        logic [N-1:0] s;
        for (int i = 0; i < N; i++) s[i] = v[i*DW + DW - 1];
        return s;
    endfunction

    // ---------------- instance 1: MIN_PASS = 1 ----------------
    logic          in_valid = 1'b0, in_ready, arr_clr, arr_en, syn_ok;
    logic [LW-1:0] in_llr = '0, arr_l;
    logic [IW-1:0] max_iter = '0, out_iters;
    logic [N-1:0]  arr_dec, out_bits;
    logic          out_valid, out_ready = 1'b1;
    logic [1:0]    out_status;
    logic [SW-1:0] cnt_ok, cnt_fail;
    int            en_cnt = 0;
    int            syn_at = 0;
    exp_t          q[$];

    ldpc_core_sched #(
        .data_w(DW), .R(R), .D(D), .IT_W(IW), .MIN_PASS(1), .ST_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
        .max_iter(max_iter), .arr_l(arr_l), .arr_clr(arr_clr), .arr_en(arr_en),
        .arr_dec(arr_dec), .syn_ok(syn_ok), .out_valid(out_valid), .out_ready(out_ready),
        .out_bits(out_bits), .out_iters(out_iters), .out_status(out_status),
        .cnt_ok(cnt_ok), .cnt_fail(cnt_fail)
    );

    always_ff @(posedge clk) begin
        if (!rst || arr_clr) en_cnt <= 0;
        else if (arr_en) en_cnt <= en_cnt + 1;
    end
    assign syn_ok  = (en_cnt >= syn_at);
    assign arr_dec = signs(arr_l) ^ {N{en_cnt[0]}};

    // ---------------- instance 2: MIN_PASS = 2 ----------------
    logic          in_valid2 = 1'b0, in_ready2, arr_clr2, arr_en2, syn_ok2;
    logic [LW-1:0] in_llr2 = '0, arr_l2;
    logic [IW-1:0] max_iter2 = 6'd10, out_iters2;
    logic [N-1:0]  arr_dec2, out_bits2;
    logic          out_valid2;
    logic [1:0]    out_status2;
    logic [SW-1:0] cnt_ok2, cnt_fail2;
    int            en_cnt2 = 0;
    exp_t          q2[$];

    ldpc_core_sched #(
        .data_w(DW), .R(R), .D(D), .IT_W(IW), .MIN_PASS(2), .ST_W(SW)
    ) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_llr(in_llr2),
        .max_iter(max_iter2), .arr_l(arr_l2), .arr_clr(arr_clr2), .arr_en(arr_en2),
        .arr_dec(arr_dec2), .syn_ok(syn_ok2), .out_valid(out_valid2), .out_ready(1'b1),
        .out_bits(out_bits2), .out_iters(out_iters2), .out_status(out_status2),
        .cnt_ok(cnt_ok2), .cnt_fail(cnt_fail2)
    );

    always_ff @(posedge clk) begin
        if (!rst || arr_clr2) en_cnt2 <= 0;
        else if (arr_en2) en_cnt2 <= en_cnt2 + 1;
    end
    // One-cycle pass at count 2, then steady pass from count 5.
    assign syn_ok2  = (en_cnt2 == 2) || (en_cnt2 >= 5);
    assign arr_dec2 = signs(arr_l2) ^ {N{en_cnt2[0]}};

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got bits %0h, required no result", out_bits);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_bits", out_bits, e.bits);
                check("out_iters", out_iters, e.iters);
                check("out_status", out_status, e.st);
            end
        end
        if (out_valid2) begin
            if (q2.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result2: got bits %0h, required no result", out_bits2);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("out_bits2", out_bits2, e.bits);
                check("out_iters2", out_iters2, e.iters);
                check("out_status2", out_status2, e.st);
            end
        end
    end

    // ---------------- stimulus helpers (aligned to posedge + 1) ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected bits: array model flips all signs when the iteration count is odd.
    task automatic send(input logic [LW-1:0] v, input logic [IW-1:0] it, input logic [1:0] st);
        exp_t e;
        int   n;
        e.bits  = signs(v) ^ {N{it[0]}};
        e.iters = it;
        e.st    = st;
        q.push_back(e);
        in_llr   = v;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL in_ready_timeout: got in_ready=0, required 1");
        end
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || q2.size() != 0) && n < 500) begin
            tick(1);
            n++;
        end
        if (q.size() != 0 || q2.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d pending, required 0", q.size() + q2.size());
            q.delete();
            q2.delete();
        end
        tick(1);
    endtask

    initial begin
        tick(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_bits", out_bits, 0);
        check("rst_out_iters", out_iters, 0);
        check("rst_out_status", out_status, 0);
        check("rst_cnt_ok", cnt_ok, 0);
        check("rst_cnt_fail", cnt_fail, 0);
        check("rst_arr_en", arr_en, 0);
        check("rst_arr_clr", arr_clr, 0);
        rst = 1'b1;
        tick(2);

        // 1: already satisfies parity
        syn_at = 0; max_iter = 6'd10;
        send(40'h84_2108_4210, 6'd0, 2'b01);
        drain();
        check("t1_cnt_ok", cnt_ok, 1);
        check("t1_en_pulses", en_cnt, 0);

        // 2: converges after 4 iterations
        syn_at = 4; max_iter = 6'd10;
        send(40'hF0_0F0F_00FF, 6'd4, 2'b01);
        drain();
        check("t2_en_pulses", en_cnt, 4);
        check("t2_cnt_ok", cnt_ok, 2);

        // 3: never converges, limit 7
        syn_at = 1000; max_iter = 6'd7;
        send(40'h12_3456_789A, 6'd7, 2'b10);
        drain();
        check("t3_en_pulses", en_cnt, 7);
        check("t3_cnt_fail", cnt_fail, 1);

        // max_iter = 0 both ways
        syn_at = 1000; max_iter = 6'd0;
        send(40'hAA_5555_AAAA, 6'd0, 2'b10);
        drain();
        check("z_timeout_cnt_fail", cnt_fail, 2);
        syn_at = 0;
        send(40'h55_AAAA_5555, 6'd0, 2'b01);
        drain();
        check("z_conv_cnt_ok", cnt_ok, 3);
        check("z_en_pulses", en_cnt, 0);

        // 4: three frames back to back with downstream stalled
        syn_at = 2; max_iter = 6'd10; out_ready = 1'b0;
        send(40'h80_0000_0001, 6'd2, 2'b01);
        send(40'h00_8400_0021, 6'd2, 2'b01);
        check("t4_in_ready_full", in_ready, 0);
        send(40'hFF_FFFF_FFFF, 6'd2, 2'b01);
        tick(20);
        check("t4_stall_in_ready", in_ready, 0);
        check("t4_stall_out_valid", out_valid, 1);
        check("t4_stall_arr_en", arr_en, 0);
        check("t4_stall_en_pulses", en_cnt, 2);
        out_ready = 1'b1;
        drain();
        check("t4_in_ready_back", in_ready, 1);
        check("t4_cnt_ok", cnt_ok, 6);

        // 6: MIN_PASS=2, isolated pass must not stop; stops on 2nd of a pair
        begin
            exp_t e;
            e.bits = signs(40'h3C_C3C3_3CC3); e.iters = 6'd6; e.st = 2'b01;
            q2.push_back(e);
        end
        in_llr2 = 40'h3C_C3C3_3CC3;
        in_valid2 = 1'b1;
        check("t6_in_ready2", in_ready2, 1);
        tick(1);
        in_valid2 = 1'b0;
        drain();
        check("t6_en_pulses", en_cnt2, 6);
        check("t6_cnt_ok2", cnt_ok2, 1);
        check("t6_cnt_fail2", cnt_fail2, 0);

        // 5: reset in the middle of RUN at iter 3, second frame queued
        syn_at = 1000; max_iter = 6'd20;
        send(40'h11_1111_1111, 6'd0, 2'b10);
        send(40'h22_2222_2222, 6'd0, 2'b10);
        begin
            int n;
            n = 0;
            while (en_cnt != 3 && n < 100) begin
                tick(1);
                n++;
            end
            check("t5_reach_iter3", en_cnt, 3);
        end
        check("t5_pre_in_ready", in_ready, 0);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        q.delete();
        check("t5_out_valid", out_valid, 0);
        check("t5_in_ready", in_ready, 1);
        check("t5_cnt_ok", cnt_ok, 0);
        check("t5_cnt_fail", cnt_fail, 0);
        check("t5_arr_en", arr_en, 0);
        tick(3);
        check("t5_idle_arr_clr", arr_clr, 0);
        check("t5_idle_arr_en", arr_en, 0);

        // Recovery after reset
        syn_at = 0; max_iter = 6'd5;
        send(40'h9C_6B3A_01F7, 6'd0, 2'b01);
        drain();
        check("rec_cnt_ok", cnt_ok, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
